// File: rtl/tl_pkg.sv
// tl_pkg: phase codes and light encodings shared by the traffic-light phase controller.
// Build option: define TL_ALL_RED_EN to add the all-red clearance phases AR1 and AR2.
package tl_pkg;

    // Phase codes, also exported on the debug state port.
    // Codes 4 and 5 exist only when the all-red feature is built in.
    typedef enum logic [2:0] {
        HG = 3'd0,
        HY = 3'd1,
        FG = 3'd2,
        FY = 3'd3
`ifdef TL_ALL_RED_EN
        ,
        AR1 = 3'd4,
        AR2 = 3'd5
`endif
    } phase_t;

    // Light head encodings; 2'b11 is never driven.
    localparam logic [1:0] LT_RED = 2'b00;
    localparam logic [1:0] LT_YEL = 2'b01;
    localparam logic [1:0] LT_GRN = 2'b10;

endpackage

// File: rtl/tl_phase_timer.sv
// tl_phase_timer: counts cycles spent in the current phase.
// The count clears when the controller signals a phase change and saturates at all-ones,
// so a phase that dwells for a long time never wraps back to small values.
module tl_phase_timer #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic [CW-1:0] timer
);

    localparam logic [CW-1:0] TIMER_MAX = {CW{1'b1}};

    // Clear on phase change, otherwise count up and hold at the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (clr) begin
            timer <= '0;
        end else if (timer != TIMER_MAX) begin
            timer <= timer + CW'(1);
        end
    end

endmodule

// File: rtl/tl_phase_ctrl.sv
// tl_phase_ctrl: phase FSM for the highway/farm-road intersection.
// Sequences HG -> HY -> FG -> FY -> HG using a phase timer that clears on every phase change,
// and pulses st for the first cycle of each newly entered phase.
// Build option: TL_ALL_RED_EN inserts AR1 (after HY) and AR2 (after FY), both heads red.
module tl_phase_ctrl
    import tl_pkg::*;
#(
    parameter int T_LONG  = 30,
    parameter int T_SHORT = 15,
    parameter int T_YEL   = 5,
    parameter int T_AR    = 2,
    parameter int CW      = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          farm_car,
    output logic [1:0]    hw_light,
    output logic [1:0]    farm_light,
    output logic          st,
    output logic [2:0]    state,
    output logic [CW-1:0] timer
);

    // Timer value seen during the last cycle of each bounded phase.
    localparam logic [CW-1:0] LONG_LAST  = CW'(T_LONG - 1);
    localparam logic [CW-1:0] SHORT_LAST = CW'(T_SHORT - 1);
    localparam logic [CW-1:0] YEL_LAST   = CW'(T_YEL - 1);
`ifdef TL_ALL_RED_EN
    localparam logic [CW-1:0] AR_LAST    = CW'(T_AR - 1);
`endif

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       st_q;
    logic       phase_change;
    logic       to_long;
    logic       to_short;
    logic       to_yel;
`ifdef TL_ALL_RED_EN
    logic       to_ar;
`endif

    // Timeouts come straight from the registered timer; HG uses >= because the timer may
    // have saturated while no farm vehicle was waiting.
    assign to_long  = (timer >= LONG_LAST);
    assign to_short = (timer == SHORT_LAST);
    assign to_yel   = (timer == YEL_LAST);
`ifdef TL_ALL_RED_EN
    assign to_ar    = (timer == AR_LAST);
`endif

    tl_phase_timer #(
        .CW(CW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (phase_change),
        .timer (timer)
    );

    // Phase register plus the strobe that marks the first cycle of a new phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HG;
            st_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= phase_change;
        end
    end

    // Next-phase selection; farm_car only matters in HG and FG, illegal codes recover via HY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HG: begin
                if (to_long && farm_car) begin
                    state_d = HY;
                end
            end
            HY: begin
                if (to_yel) begin
`ifdef TL_ALL_RED_EN
                    state_d = AR1;
`else
                    state_d = FG;
`endif
                end
            end
            FG: begin
                if (to_short || !farm_car) begin
                    state_d = FY;
                end
            end
            FY: begin
                if (to_yel) begin
`ifdef TL_ALL_RED_EN
                    state_d = AR2;
`else
                    state_d = HG;
`endif
                end
            end
`ifdef TL_ALL_RED_EN
            AR1: begin
                if (to_ar) begin
                    state_d = FG;
                end
            end
            AR2: begin
                if (to_ar) begin
                    state_d = HG;
                end
            end
`endif
            default: begin
                state_d = HY;
            end
        endcase
        phase_change = (state_d != state_q);
    end

    // Light heads decode directly from the phase register; unknown codes show highway yellow.
    always_comb begin
        hw_light   = LT_RED;
        farm_light = LT_RED;
        case (state_q)
            HG: hw_light   = LT_GRN;
            HY: hw_light   = LT_YEL;
            FG: farm_light = LT_GRN;
            FY: farm_light = LT_YEL;
`ifdef TL_ALL_RED_EN
            AR1, AR2: begin
                hw_light   = LT_RED;
                farm_light = LT_RED;
            end
`endif
            default: hw_light = LT_YEL;
        endcase
    end

    assign state = state_q;
    assign st    = st_q;

endmodule

// File: tb/tb_tl_phase_ctrl.sv
// tb_tl_phase_ctrl: self-checking bench for tl_phase_ctrl.
// Directed vector table for a full cycle, hand sequences for saturation, early FG exit,
// asynchronous reset and illegal-state recovery, then random farm traffic against a
// duration-based reference model. Honours TL_ALL_RED_EN when defined.
module tb_tl_phase_ctrl;

    localparam int CW      = 5;
    localparam int T_LONG  = 30;
    localparam int T_SHORT = 15;
    localparam int T_YEL   = 5;
    localparam int T_AR    = 2;
    localparam int TMAX    = (1 << CW) - 1;

    localparam int P_HG  = 0;
    localparam int P_HY  = 1;
    localparam int P_FG  = 2;
    localparam int P_FY  = 3;
    localparam int P_AR1 = 4;
    localparam int P_AR2 = 5;
    localparam int P_BAD = 6;

    localparam logic [1:0] L_R = 2'b00;
    localparam logic [1:0] L_Y = 2'b01;
    localparam logic [1:0] L_G = 2'b10;

`ifdef TL_ALL_RED_EN
    localparam bit ALL_RED  = 1'b1;
    localparam int AR_EDGES = T_AR;
`else
    localparam bit ALL_RED  = 1'b0;
    localparam int AR_EDGES = 0;
`endif

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          farm_car = 1'b0;
    logic [1:0]    hw_light;
    logic [1:0]    farm_light;
    logic          st;
    logic [2:0]    state;
    logic [CW-1:0] timer;

    int total = 0;
    int bad   = 0;

    // Reference model: phase, cycles already spent in it, and whether it was just entered.
    int mPhase = P_HG;
    int mAge   = 0;
    bit mSt    = 1'b0;

    typedef struct {
        string name;
        int    edges;
        logic  farm;
        int    expState;
        int    expTimer;
        logic  expSt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    tl_phase_ctrl #(
        .T_LONG (T_LONG),
        .T_SHORT(T_SHORT),
        .T_YEL  (T_YEL),
        .T_AR   (T_AR),
        .CW     (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .farm_car  (farm_car),
        .hw_light  (hw_light),
        .farm_light(farm_light),
        .st        (st),
        .state     (state),
        .timer     (timer)
    );

    function automatic logic [1:0] phaseHw(input int p);
        case (p)
            P_HG:    return L_G;
            P_HY:    return L_Y;
            P_FG, P_FY, P_AR1, P_AR2: return L_R;
            default: return L_Y;
        endcase
    endfunction

    function automatic logic [1:0] phaseFarm(input int p);
        case (p)
            P_FG:    return L_G;
            P_FY:    return L_Y;
            default: return L_R;
        endcase
    endfunction

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input int expState, input int expTimer, input logic expSt);
        checkVal({tag, ".state"}, 32'(state), 32'(expState));
        checkVal({tag, ".timer"}, 32'(timer), 32'(expTimer));
        checkVal({tag, ".st"}, 32'(st), 32'(expSt));
        checkVal({tag, ".hw"}, 32'(hw_light), 32'(phaseHw(expState)));
        checkVal({tag, ".farm"}, 32'(farm_light), 32'(phaseFarm(expState)));
    endtask

    task automatic applyStimulus(input logic f, input int n);
        farm_car = f;
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        farm_car = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic modelReset();
        mPhase = P_HG;
        mAge   = 0;
        mSt    = 1'b0;
    endtask

    // Advance the model across one rising edge, using phase-length rules.
    task automatic modelAdvance(input logic f);
        int dwell;
        int nxt;
        dwell = mAge + 1;
        nxt   = mPhase;
        case (mPhase)
            P_HG:  if (f && dwell >= T_LONG) nxt = P_HY;
            P_HY:  if (dwell == T_YEL) nxt = ALL_RED ? P_AR1 : P_FG;
            P_FG:  if (!f || dwell == T_SHORT) nxt = P_FY;
            P_FY:  if (dwell == T_YEL) nxt = ALL_RED ? P_AR2 : P_HG;
            P_AR1: if (dwell == T_AR) nxt = P_FG;
            P_AR2: if (dwell == T_AR) nxt = P_HG;
            default: nxt = P_HY;
        endcase
        if (nxt != mPhase) begin
            mPhase = nxt;
            mAge   = 0;
            mSt    = 1'b1;
        end else begin
            mAge = mAge + 1;
            mSt  = 1'b0;
        end
    endtask

    // Safety invariant, sampled every cycle away from the rising edge.
    always @(negedge clk) begin
        total++;
        if (hw_light !== L_R && farm_light !== L_R) begin
            bad++;
            $display("[TB] FAIL invariant: hw=%b farm=%b, required one head red (t=%0t)", hw_light, farm_light, $time);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic f;

        #2 rst_n = 1'b0;

        // Full cycle with a farm vehicle always waiting.
        vecs.push_back('{"hg_start",  0,  1'b1, P_HG, 0,  1'b0});
        vecs.push_back('{"hg_last",   29, 1'b1, P_HG, 29, 1'b0});
        vecs.push_back('{"hy_enter",  1,  1'b1, P_HY, 0,  1'b1});
        vecs.push_back('{"hy_second", 1,  1'b1, P_HY, 1,  1'b0});
        vecs.push_back('{"hy_last",   3,  1'b1, P_HY, 4,  1'b0});
`ifdef TL_ALL_RED_EN
        vecs.push_back('{"ar1_enter", 1,  1'b1, P_AR1, 0, 1'b1});
        vecs.push_back('{"ar1_last",  1,  1'b1, P_AR1, 1, 1'b0});
`endif
        vecs.push_back('{"fg_enter",  1,  1'b1, P_FG, 0,  1'b1});
        vecs.push_back('{"fg_last",   14, 1'b1, P_FG, 14, 1'b0});
        vecs.push_back('{"fy_enter",  1,  1'b1, P_FY, 0,  1'b1});
        vecs.push_back('{"fy_last",   4,  1'b1, P_FY, 4,  1'b0});
`ifdef TL_ALL_RED_EN
        vecs.push_back('{"ar2_enter", 1,  1'b1, P_AR2, 0, 1'b1});
        vecs.push_back('{"ar2_last",  1,  1'b1, P_AR2, 1, 1'b0});
`endif
        vecs.push_back('{"hg_return", 1,  1'b1, P_HG, 0,  1'b1});
        vecs.push_back('{"hg_second", 1,  1'b1, P_HG, 1,  1'b0});

        $display("[TB] directed full cycle");
        doReset();
        checkOutput("reset", P_HG, 0, 1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].farm, vecs[i].edges);
            checkOutput(vecs[i].name, vecs[i].expState, vecs[i].expTimer, vecs[i].expSt);
        end

        $display("[TB] HG dwell with no farm vehicle");
        doReset();
        for (int k = 1; k <= 100; k++) begin
            applyStimulus(1'b0, 1);
            checkOutput("hg_idle", P_HG, (k > TMAX) ? TMAX : k, 1'b0);
        end

        $display("[TB] farm vehicle leaves early in FG");
        doReset();
        applyStimulus(1'b1, T_LONG + T_YEL + AR_EDGES);
        checkOutput("early_fg_enter", P_FG, 0, 1'b1);
        applyStimulus(1'b1, 3);
        checkOutput("early_fg_t3", P_FG, 3, 1'b0);
        applyStimulus(1'b0, 1);
        checkOutput("early_fy_enter", P_FY, 0, 1'b1);

        $display("[TB] asynchronous reset in FG");
        doReset();
        applyStimulus(1'b1, T_LONG + T_YEL + AR_EDGES + 7);
        checkOutput("pre_reset_fg", P_FG, 7, 1'b0);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset", P_HG, 0, 1'b0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("restart_t1", P_HG, 1, 1'b0);
        applyStimulus(1'b1, 28);
        checkOutput("restart_hg_last", P_HG, 29, 1'b0);
        applyStimulus(1'b1, 1);
        checkOutput("restart_hy", P_HY, 0, 1'b1);

        $display("[TB] illegal state recovery");
        doReset();
        applyStimulus(1'b0, 10);
        force dut.state_q = 3'd6;
        #1 release dut.state_q;
        #1 checkOutput("illegal_hold", P_BAD, 10, 1'b0);
        @(negedge clk);
        checkOutput("illegal_to_hy", P_HY, 0, 1'b1);
        applyStimulus(1'b0, 4);
        checkOutput("illegal_hy_last", P_HY, 4, 1'b0);
        applyStimulus(1'b0, 1 + AR_EDGES);
        checkOutput("one_cycle_fg", P_FG, 0, 1'b1);
        applyStimulus(1'b0, 1);
        checkOutput("one_cycle_fg_exit", P_FY, 0, 1'b1);

        $display("[TB] random farm traffic against model");
        doReset();
        modelReset();
        f = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            checkOutput("rand", mPhase, (mAge > TMAX) ? TMAX : mAge, mSt);
            if ($urandom_range(0, 19) == 0) f = ~f;
            farm_car = f;
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
                modelReset();
            end
            modelAdvance(f);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
